// File: rtl/store_queue_pkg.sv
// Shared types and helpers for the store queue.
//   sq_entry_t  : one queued store (word address, lane-aligned data, byte enables)
//   NUM_LANES   : byte lanes per 32-bit word
//   adr_match() : word-address compare used by the forwarding network
package store_queue_pkg;

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [29:0] adr_w;  // word address, byte address bits [31:2]
    logic [31:0] data;   // lane-aligned store data
    logic [3:0]  be;     // bit i enables byte lane i
  } sq_entry_t;

  function automatic logic adr_match(input logic [29:0] entry_adr_w,
                                     input logic [29:0] ld_adr_w);
    return entry_adr_w == ld_adr_w;
  endfunction

endpackage

// File: rtl/store_queue_fwd.sv
// Combinational store-to-load forwarding over the queued entries.
//   entries  : queue storage, indexed by physical slot
//   head     : slot of the oldest valid entry
//   count    : number of valid entries, 0..DEPTH
//   ld_adr_w : load word address
//   dram_rd  : raw DRAM word for the load address
//   ld_data  : per-lane merge, youngest matching enabled entry wins, else DRAM
module store_queue_fwd
  import store_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sq_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [29:0]       ld_adr_w,
  input  logic [31:0]       dram_rd,
  output logic [31:0]       ld_data
);

  // Walk oldest to youngest so a younger match simply overwrites an older
  // one in the same lane; the last write per lane is the youngest store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every variable gets a value before any conditional logic so no
    // path through the block leaves it unassigned, which would infer a latch.
    ld_data = dram_rd;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);  // pointer width makes the slot index wrap
      if ((PTR_W+1)'(k) < count && adr_match(entries[idx].adr_w, ld_adr_w)) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (entries[idx].be[i]) ld_data[8*i +: 8] = entries[idx].data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// In-order store buffer between the MEM stage and the DRAM write port.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   st_valid/adr/wdata/be, st_stall : store enqueue side; stall while full
//   ld_adr, dram_rd, ld_data        : load path with byte-wise forwarding
//   dram_we/adr/wdata/be, dram_ready: head entry drained one per handshake
//   empty, full                     : occupancy flags
module store_queue
  import store_queue_pkg::*;
#(
  parameter  int DEPTH = 4,  // power of two, 2..16
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_adr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  output logic        st_stall,
  input  logic [31:0] ld_adr,
  input  logic [31:0] dram_rd,
  output logic [31:0] ld_data,
  output logic        dram_we,
  output logic [31:0] dram_adr,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_be,
  input  logic        dram_ready,
  output logic        empty,
  output logic        full
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  sq_entry_t        mem_q [DEPTH];
  sq_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             enq, pop;

  // Stores are word-aligned; the byte offset bits carry no information.
  logic unused_adr_lsbs;
  assign unused_adr_lsbs = ^{st_adr[1:0], ld_adr[1:0]};

  assign full     = count_q == DEPTH_CNT;
  assign empty    = count_q == '0;
  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for this cycle's store.
  assign st_stall = st_valid && full;
  assign enq      = st_valid && !full;
  assign pop      = !empty && dram_ready;

  // Write port comes straight from storage: no input-to-output path.
  assign dram_we    = !empty;
  assign dram_adr   = {mem_q[head_q].adr_w, 2'b00};
  assign dram_wdata = mem_q[head_q].data;
  assign dram_be    = mem_q[head_q].be;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      mem_d[tail_q] = '{adr_w: st_adr[31:2], data: st_wdata, be: st_be};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    unique case ({enq, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately left out of reset; count gates
  // every use of it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  store_queue_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries  (mem_q),
    .head     (head_q),
    .count    (count_q),
    .ld_adr_w (ld_adr[31:2]),
    .dram_rd  (dram_rd),
    .ld_data  (ld_data)
  );

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: a queue-based reference model checked
// against the DUT every cycle, plus directed literal expectations.
module tb_store_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_adr, st_wdata;
  logic [3:0]  st_be;
  logic        st_stall;
  logic [31:0] ld_adr, dram_rd, ld_data;
  logic        dram_we;
  logic [31:0] dram_adr, dram_wdata;
  logic [3:0]  dram_be;
  logic        dram_ready;
  logic        empty, full;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [63:0] wlog[$];
  bit          m_pop, m_enq;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_adr     (st_adr),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .st_stall   (st_stall),
    .ld_adr     (ld_adr),
    .dram_rd    (dram_rd),
    .ld_data    (ld_data),
    .dram_we    (dram_we),
    .dram_adr   (dram_adr),
    .dram_wdata (dram_wdata),
    .dram_be    (dram_be),
    .dram_ready (dram_ready),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load: start from DRAM, overlay each matching store oldest first.
  function automatic logic [31:0] model_load(input logic [31:0] adr, input logic [31:0] raw);
    logic [31:0] r;
    r = raw;
    foreach (mq[k]) begin
      if (mq[k].adr[31:2] == adr[31:2]) begin
        for (int i = 0; i < 4; i++)
          if (mq[k].be[i]) r[8*i +: 8] = mq[k].data[8*i +: 8];
      end
    end
    return r;
  endfunction

  // Model state update on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_pop = mq.size() != 0 && dram_ready;
      m_enq = st_valid && mq.size() < DEPTH;
      if (m_pop) void'(mq.pop_front());
      if (m_enq) mq.push_back('{adr: {st_adr[31:2], 2'b00}, data: st_wdata, be: st_be});
    end
  end

  // Every-cycle comparison and DRAM write logging.
  always @(negedge clk) begin
    if (model_on) begin
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("st_stall", 32'(st_stall), 32'(st_valid && mq.size() == DEPTH));
      check("dram_we",  32'(dram_we),  32'(mq.size() != 0));
      check("ld_data",  ld_data,       model_load(ld_adr, dram_rd));
      if (mq.size() != 0) begin
        check("dram_adr",   dram_adr,       mq[0].adr);
        check("dram_wdata", dram_wdata,     mq[0].data);
        check("dram_be",    32'(dram_be),   32'(mq[0].be));
      end
      if (!rst && dram_we && dram_ready) wlog.push_back({dram_adr, dram_wdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    st_valid = 1'b1;
    st_adr   = a;
    st_wdata = d;
    st_be    = b;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_adr = '0; st_wdata = '0; st_be = '0;
    ld_adr = '0; dram_rd = '0; dram_ready = 1'b0;
    @(posedge clk);
    model_on = 1'b1;
    @(posedge clk);
    at_neg();
    check("rst_empty",   32'(empty),    32'd1);
    check("rst_dram_we", 32'(dram_we),  32'd0);
    check("rst_full",    32'(full),     32'd0);
    check("rst_stall",   32'(st_stall), 32'd0);
    step();
    rst = 1'b0;

    // Single full-word store, then forward it.
    set_store(32'h100, 32'hAABBCCDD, 4'hF);
    step();
    st_valid = 1'b0; ld_adr = 32'h100; dram_rd = 32'h0;
    at_neg();
    check("t1_dram_we",  32'(dram_we), 32'd1);
    check("t1_dram_adr", dram_adr,     32'h100);
    check("t1_empty",    32'(empty),   32'd0);
    check("t1_ld",       ld_data,      32'hAABBCCDD);
    step();
    dram_ready = 1'b1; step(); dram_ready = 1'b0;

    // Partial byte merge from two stores plus DRAM.
    set_store(32'h200, 32'h000000EE, 4'b0001); step();
    set_store(32'h200, 32'h00110000, 4'b0100); step();
    st_valid = 1'b0; ld_adr = 32'h202; dram_rd = 32'h12345678;
    at_neg();
    check("t2_merge", ld_data, 32'h121156EE);
    step();
    dram_ready = 1'b1; step(); step(); dram_ready = 1'b0;

    // Youngest wins, including across the head pop.
    set_store(32'h300, 32'h1, 4'hF); step();
    set_store(32'h300, 32'h2, 4'hF); step();
    st_valid = 1'b0; ld_adr = 32'h300; dram_rd = 32'hCAFEF00D;
    at_neg();
    check("t3_young", ld_data, 32'h2);
    step();
    dram_ready = 1'b1;
    at_neg();
    check("t3_popcyc", ld_data, 32'h2);
    step();
    dram_ready = 1'b0;
    at_neg();
    check("t3_after1", ld_data, 32'h2);
    step();
    dram_ready = 1'b1; step(); dram_ready = 1'b0;
    at_neg();
    check("t3_after2", ld_data, 32'hCAFEF00D);
    check("t3_empty",  32'(empty), 32'd1);
    step();

    // Fill, stall, and same-cycle drain does not admit the store.
    for (int i = 0; i < 4; i++) begin
      set_store(32'h400 + 32'(4 * i), 32'(i + 1), 4'hF);
      step();
    end
    set_store(32'h500, 32'h55, 4'hF);
    at_neg();
    check("t4_stall", 32'(st_stall), 32'd1);
    check("t4_full",  32'(full),     32'd1);
    step();
    dram_ready = 1'b1;
    at_neg();
    check("t4_stall_pop", 32'(st_stall), 32'd1);
    step();
    dram_ready = 1'b0;
    at_neg();
    check("t4_accept", 32'(st_stall), 32'd0);
    check("t4_notfull", 32'(full),    32'd0);
    step();
    st_valid = 1'b0;
    at_neg();
    check("t4_refull", 32'(full), 32'd1);
    step();
    dram_ready = 1'b1;
    repeat (4) step();
    dram_ready = 1'b0;
    at_neg();
    check("t4_drained", 32'(empty), 32'd1);
    step();

    // Continuous drain with back-to-back stores; pointers wrap.
    wlog.delete();
    dram_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_store(32'(4 * i), 32'hD0D00000 + 32'(i), 4'hF);
      step();
      check("t5_notfull", 32'(full), 32'd0);
    end
    st_valid = 1'b0;
    step(); step();
    dram_ready = 1'b0;
    check("t5_count", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < wlog.size()) begin
        check("t5_adr",  wlog[i][63:32], 32'(4 * i));
        check("t5_data", wlog[i][31:0],  32'hD0D00000 + 32'(i));
      end
    end

    // Reset with entries queued and a live handshake + store.
    set_store(32'h600, 32'h6, 4'hF); step();
    set_store(32'h604, 32'h7, 4'hF); step();
    set_store(32'h608, 32'h8, 4'hF); step();
    rst = 1'b1; dram_ready = 1'b1; set_store(32'h700, 32'h9, 4'hF);
    step();
    rst = 1'b0; st_valid = 1'b0; dram_ready = 1'b0;
    ld_adr = 32'h604; dram_rd = 32'h0BADBEEF;
    at_neg();
    check("t6_empty",   32'(empty),   32'd1);
    check("t6_dram_we", 32'(dram_we), 32'd0);
    check("t6_ld",      ld_data,      32'h0BADBEEF);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Small in-order store buffer between the MEM stage and the data DRAM write port.
- Retiring stores enqueue in one cycle; the queue drains them to DRAM one per accepted handshake.
- Loads are never blocked by pending stores: load data is merged per byte from queued stores over the raw DRAM read word.
- Replaces single-entry last-store forwarding with a DEPTH-entry queue and byte-enable-aware forwarding.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Synchronous reset, active-high.
- st_valid  input  1  MEM stage presents a store this cycle.
- st_adr  input  32  Store byte address; bits [1:0] ignored, word-aligned.
- st_wdata  input  32  Store data, already lane-aligned.
- st_be  input  4  Byte enables; bit i covers byte lane i (bits 8i+7:8i).
- st_stall  output  1  Store not accepted this cycle; pipeline must hold.
- ld_adr  input  32  Load address; bits [1:0] ignored.
- dram_rd  input  32  Raw DRAM read word for ld_adr.
- ld_data  output  32  Forwarded and merged load word.
- dram_we  output  1  Head entry valid; write request to DRAM.
- dram_adr  output  32  Head entry address, with [1:0] = 0.
- dram_wdata  output  32  Head entry data.
- dram_be  output  4  Head entry byte enables.
- dram_ready  input  1  DRAM accepts the write this cycle.
- empty  output  1  Count is 0.
- full  output  1  Count is DEPTH.

Behaviour:
- Storage:
  - Circular buffer with head pointer, tail pointer and count, each PTR_W bits; count is PTR_W+1 bits.
  - Entry fields: word address [31:2], data [31:0], be [3:0].
- Enqueue:
  - Occurs at posedge when st_valid && !full && !rst.
  - Writes the entry at tail; tail wraps from DEPTH-1 to 0.
  - st_valid with st_be == 0 is accepted and enqueued; it drains as a no-op write.
- st_stall:
  - Combinational: st_valid && full.
  - A drain in the same cycle does not free a slot for that cycle's enqueue.
- Drain:
  - dram_we = !empty. dram_adr, dram_wdata and dram_be are driven directly from the head entry (registered storage, no combinational path from inputs).
  - Pop at posedge when dram_we && dram_ready; head wraps from DEPTH-1 to 0.
  - Outputs stay stable while dram_we && !dram_ready.
- Simultaneous enqueue and pop: count unchanged, both pointers advance.
- Count transitions: enqueue only, count+1; pop only, count-1; neither or both, unchanged.
- Forwarding (combinational, zero latency):
  - For each byte lane i, ld_data lane i comes from the youngest valid entry whose word address equals ld_adr[31:2] and whose be[i] = 1.
  - If no such entry exists, the lane comes from dram_rd lane i.
  - "Youngest" means nearest to tail, walking backwards.
  - The head entry forwards normally even in its pop cycle.
  - A store presented in the same cycle (not yet enqueued) is NOT forwarded; the pipeline hazard unit handles same-cycle store-load.
- Ordering: strict FIFO; no write combining, no reordering.
- Reset (synchronous):
  - head = tail = count = 0.
  - dram_we = 0, empty = 1, full = 0, st_stall = 0 (given st_valid = 0).
  - Pending stores are discarded.
  - Entry contents need no reset.
  - Reset asserted mid-handshake wins over pop and enqueue.

Decomposition:
- Shared package:
  - Entry struct (adr_w [29:0], data [31:0], be [3:0]).
  - Byte-lane count constant (4).
  - Function for the word-address compare.
- One natural sub-module: store_queue_fwd, the combinational per-lane priority merge over the DEPTH entries, the head pointer and count.
- The top level holds the pointers, count and storage.

Test Plan:
- Reset, then enqueue a store with adr=0x100, data=0xAABBCCDD, be=4'hF, dram_ready=0 → next cycle dram_we=1, dram_adr=0x100, empty=0; a load at 0x100 with dram_rd=0 returns 0xAABBCCDD.
- Partial merge:
  - Enqueue adr 0x200, be=4'b0001, data 0x000000EE.
  - Then enqueue adr 0x200, be=4'b0100, data 0x00110000.
  - Load 0x200 with dram_rd=0x12345678 → ld_data=0x121156EE.
- Youngest wins: two full-word stores to 0x300 (0x1, then 0x2), undrained → load 0x300 returns 0x2. After one pop the load still returns 0x2; after both pops it returns dram_rd.
- Full: fill 4 entries with dram_ready=0, then assert st_valid → st_stall=1, full=1, count stays 4.
  - Next, assert dram_ready for one cycle with st_valid held: that cycle still stalls; the following cycle accepts and count returns to 4.
- Wrap and simultaneous: with dram_ready=1 continuously, enqueue 10 sequential stores 0x0..0x24 → DRAM sees exactly those 10 writes in order; count never exceeds 1; both pointers wrap.
- Reset mid-operation: 3 entries queued, dram_ready=0, assert rst for one cycle → next cycle empty=1, dram_we=0, and a load of a previously queued address returns dram_rd.
